// File: rtl/bin_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (double-dabble), BPC bits per cycle,
// valid/ready on both sides, with overflow and significant-digit reporting.
module bin_bcd_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 9,
    parameter int BPC    = 4,
    parameter int SIGNED = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bin_valid,
    input  logic [BIN_W-1:0]             bin,
    output logic                         ready,
    output logic                         bcd_valid,
    input  logic                         bcd_ready,
    output logic [4*DIGITS-1:0]          bcd,
    output logic                         sign,
    output logic                         ovf,
    output logic [$clog2(DIGITS+1)-1:0]  sig_digits
);
    localparam int STEPS = (BIN_W + BPC - 1) / BPC;
    localparam int PAD_W = STEPS * BPC;
    localparam int BCD_W = 4 * DIGITS;
    localparam int SD_W  = $clog2(DIGITS + 1);
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PAD_W-1:0]   sh_q, sh_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic               sgn_q, sgn_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               ready_q, ready_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic               ovf_q, ovf_d;
    logic [SD_W-1:0]    sig_digits_q, sig_digits_d;

    logic [BIN_W:0]     ext, mag_full;
    logic               neg;
    logic [BCD_W-1:0]   acc_n;
    logic [PAD_W-1:0]   sh_n;
    logic               of_n;
    logic [SD_W-1:0]    sd_n;

    always_comb begin
        // One extra bit so that negating the most negative input is exact
        neg      = (SIGNED != 0) && bin[BIN_W-1];
        ext      = {neg, bin};
        mag_full = neg ? (~ext + 1'b1) : ext;

        acc_n = acc_q;
        sh_n  = sh_q;
        of_n  = ovf_acc_q;
        for (int s = 0; s < BPC; s++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (acc_n[4*d +: 4] >= 4'd5)
                    acc_n[4*d +: 4] = acc_n[4*d +: 4] + 4'd3;
            end
            of_n  = of_n | acc_n[BCD_W-1];
            acc_n = {acc_n[BCD_W-2:0], sh_n[PAD_W-1]};
            sh_n  = sh_n << 1;
        end

        sd_n = SD_W'(1);
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_n[4*d +: 4] != 4'd0)
                sd_n = SD_W'(d + 1);
        end

        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        acc_d        = acc_q;
        sgn_d        = sgn_q;
        ovf_acc_d    = ovf_acc_q;
        ready_d      = ready_q;
        bcd_valid_d  = bcd_valid_q;
        bcd_d        = bcd_q;
        sign_d       = sign_q;
        ovf_d        = ovf_q;
        sig_digits_d = sig_digits_q;

        case (state_q)
            S_IDLE: begin
                if (bin_valid && ready_q) begin
                    state_d   = S_CONV;
                    ready_d   = 1'b0;
                    sh_d      = '0;
                    sh_d[BIN_W-1:0] = mag_full[BIN_W-1:0];
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    sgn_d     = neg;
                    cnt_d     = '0;
                end
            end
            S_CONV: begin
                acc_d     = acc_n;
                sh_d      = sh_n;
                ovf_acc_d = of_n;
                cnt_d     = cnt_q + 1'b1;
                // Visible outputs only change here, so they hold through IDLE/CONV
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d      = S_DONE;
                    bcd_valid_d  = 1'b1;
                    bcd_d        = acc_n;
                    ovf_d        = of_n;
                    sign_d       = sgn_q;
                    sig_digits_d = sd_n;
                end
            end
            S_DONE: begin
                if (bcd_ready) begin
                    state_d     = S_IDLE;
                    bcd_valid_d = 1'b0;
                    ready_d     = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                ready_d     = 1'b1;
                bcd_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sh_q         <= '0;
            acc_q        <= '0;
            sgn_q        <= 1'b0;
            ovf_acc_q    <= 1'b0;
            ready_q      <= 1'b1;
            bcd_valid_q  <= 1'b0;
            bcd_q        <= '0;
            sign_q       <= 1'b0;
            ovf_q        <= 1'b0;
            sig_digits_q <= SD_W'(1);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            acc_q        <= acc_d;
            sgn_q        <= sgn_d;
            ovf_acc_q    <= ovf_acc_d;
            ready_q      <= ready_d;
            bcd_valid_q  <= bcd_valid_d;
            bcd_q        <= bcd_d;
            sign_q       <= sign_d;
            ovf_q        <= ovf_d;
            sig_digits_q <= sig_digits_d;
        end
    end

    assign ready      = ready_q;
    assign bcd_valid  = bcd_valid_q;
    assign bcd        = bcd_q;
    assign sign       = sign_q;
    assign ovf        = ovf_q;
    assign sig_digits = sig_digits_q;
endmodule

// File: tb/tb_bin_bcd_seq.sv
// Directed bench for bin_bcd_seq: default config plus a signed and an overflowing config.
module tb_bin_bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // u0: defaults (27 bits, 9 digits, 4 bits/cycle)
    logic        bv0 = 1'b0, rdy0, vld0, br0 = 1'b1, sg0, of0;
    logic [26:0] b0 = '0;
    logic [35:0] bcd0;
    logic [3:0]  sd0;
    // u1: signed, 8 bits, 3 digits, 1 bit/cycle
    logic        bv1 = 1'b0, rdy1, vld1, br1 = 1'b1, sg1, of1;
    logic [7:0]  b1 = '0;
    logic [11:0] bcd1;
    logic [1:0]  sd1;
    // u2: unsigned, 8 bits, 2 digits, 3 bits/cycle
    logic        bv2 = 1'b0, rdy2, vld2, br2 = 1'b1, sg2, of2;
    logic [7:0]  b2 = '0;
    logic [7:0]  bcd2;
    logic [1:0]  sd2;

    bin_bcd_seq u0 (.clk(clk), .rst(rst), .bin_valid(bv0), .bin(b0), .ready(rdy0),
        .bcd_valid(vld0), .bcd_ready(br0), .bcd(bcd0), .sign(sg0), .ovf(of0), .sig_digits(sd0));
    bin_bcd_seq #(.BIN_W(8), .DIGITS(3), .BPC(1), .SIGNED(1)) u1 (.clk(clk), .rst(rst),
        .bin_valid(bv1), .bin(b1), .ready(rdy1), .bcd_valid(vld1), .bcd_ready(br1),
        .bcd(bcd1), .sign(sg1), .ovf(of1), .sig_digits(sd1));
    bin_bcd_seq #(.BIN_W(8), .DIGITS(2), .BPC(3), .SIGNED(0)) u2 (.clk(clk), .rst(rst),
        .bin_valid(bv2), .bin(b2), .ready(rdy2), .bcd_valid(vld2), .bcd_ready(br2),
        .bcd(bcd2), .sign(sg2), .ovf(of2), .sig_digits(sd2));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [26:0] bin;
        logic [35:0] bcd;
        int          sd;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy_of(input int i);
        return (i == 0) ? rdy0 : (i == 1) ? rdy1 : rdy2;
    endfunction
    function automatic logic vld_of(input int i);
        return (i == 0) ? vld0 : (i == 1) ? vld1 : vld2;
    endfunction
    function automatic logic [63:0] bcd_of(input int i);
        return (i == 0) ? 64'(bcd0) : (i == 1) ? 64'(bcd1) : 64'(bcd2);
    endfunction
    function automatic logic [63:0] sd_of(input int i);
        return (i == 0) ? 64'(sd0) : (i == 1) ? 64'(sd1) : 64'(sd2);
    endfunction
    function automatic logic [1:0] so_of(input int i);
        return (i == 0) ? {sg0, of0} : (i == 1) ? {sg1, of1} : {sg2, of2};
    endfunction

    task automatic set_in(input int i, input logic v, input logic [26:0] b);
        case (i)
            0: begin bv0 = v; b0 = b; end
            1: begin bv1 = v; b1 = b[7:0]; end
            default: begin bv2 = v; b2 = b[7:0]; end
        endcase
    endtask

    // Returns cycles from acceptance edge to first edge with bcd_valid high (or 99 on timeout)
    task automatic wait_valid(input int i, output int n);
        n = 0;
        while (1) begin
            @(posedge clk);
            n++;
            #1;
            if (vld_of(i)) break;
            if (n >= 60) begin n = 99; break; end
        end
    endtask

    // One word through instance i with bcd_ready high; checks latency, result and handshake
    task automatic conv(input int i, input logic [26:0] b, input logic [63:0] e_bcd,
                        input int e_sd, input logic e_sign, input logic e_ovf,
                        input int e_lat, input string nm);
        int n;
        @(negedge clk);
        chk({nm, ".ready_in"}, 64'(rdy_of(i)), 64'd1);
        set_in(i, 1'b1, b);
        @(posedge clk);
        #1 set_in(i, 1'b0, b);
        wait_valid(i, n);
        chk({nm, ".latency"}, 64'(n), 64'(e_lat));
        chk({nm, ".bcd"}, bcd_of(i), e_bcd);
        chk({nm, ".sig_digits"}, sd_of(i), 64'(e_sd));
        chk({nm, ".sign_ovf"}, 64'(so_of(i)), 64'({e_sign, e_ovf}));
        @(posedge clk);
        #1 chk({nm, ".after_hs"}, 64'({vld_of(i), rdy_of(i)}), 64'b01);
    endtask

    initial begin
        vec_t tbl[6];
        int n;
        logic hold_bad;
        tbl[0] = '{27'd99_999_999,  36'h099999999, 8};
        tbl[1] = '{27'd0,           36'h000000000, 1};
        tbl[2] = '{27'h7FFFFFF,     36'h134217727, 9};
        tbl[3] = '{27'd5,           36'h000000005, 1};
        tbl[4] = '{27'd10,          36'h000000010, 2};
        tbl[5] = '{27'd123_456_789, 36'h123456789, 9};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst.u0", {vld0, rdy0, sg0, of0, sd0, bcd0}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 36'h0});
        chk("rst.u1", {vld1, rdy1, sg1, of1, sd1, bcd1}, {1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 12'h0});
        chk("rst.u2", {vld2, rdy2, sg2, of2, sd2, bcd2}, {1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'h0});

        for (int k = 0; k < 6; k++)
            conv(0, tbl[k].bin, 64'(tbl[k].bcd), tbl[k].sd, 1'b0, 1'b0, 7, $sformatf("tbl%0d", k));

        // Backpressure: result held 20 cycles, new words ignored meanwhile
        br0 = 1'b0;
        @(negedge clk);
        bv0 = 1'b1; b0 = 27'd4321;
        @(posedge clk);
        #1 bv0 = 1'b0;
        wait_valid(0, n);
        chk("bp.latency", 64'(n), 64'd7);
        hold_bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bv0 = k[0];
            b0 = 27'($urandom);
            @(posedge clk);
            #1 if (bcd0 !== 36'h4321 || vld0 !== 1'b1 || rdy0 !== 1'b0) hold_bad = 1'b1;
        end
        bv0 = 1'b0;
        chk("bp.hold", 64'(hold_bad), 64'd0);
        chk("bp.sd", 64'(sd0), 64'd4);
        @(negedge clk);
        br0 = 1'b1;
        @(posedge clk);
        #1 chk("bp.release", 64'({vld0, rdy0}), 64'b01);
        conv(0, 27'd777, 36'h777, 3, 1'b0, 1'b0, 7, "bp.next");

        // Signed, 1 bit/cycle: most negative value and -1
        conv(1, 27'h80, 64'h128, 3, 1'b1, 1'b0, 8, "s.m128");
        conv(1, 27'hFF, 64'h001, 1, 1'b1, 1'b0, 8, "s.m1");
        conv(1, 27'd127, 64'h127, 3, 1'b0, 1'b0, 8, "s.p127");

        // Too few digits: overflow, then cleared by the next word
        conv(2, 27'd255, 64'h55, 2, 1'b0, 1'b1, 3, "o.255");
        conv(2, 27'd42, 64'h42, 2, 1'b0, 1'b0, 3, "o.42");
        conv(2, 27'd100, 64'h00, 1, 1'b0, 1'b1, 3, "o.100");

        // Reset two cycles into CONV abandons the word
        @(negedge clk);
        bv0 = 1'b1; b0 = 27'd12345;
        @(posedge clk);
        #1 bv0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rstmid", {vld0, rdy0, sd0, bcd0}, {1'b0, 1'b1, 4'd1, 36'h0});
        repeat (10) begin
            @(posedge clk);
            #1 if (vld0) begin
                chk("rstmid.no_out", 64'(vld0), 64'd0);
                break;
            end
        end
        conv(0, 27'd987_654, 36'h000987654, 6, 1'b0, 1'b0, 7, "rstmid.next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
